cnt_stream_reader: RTL and testbench

- Host-side consumer of the 64-bit photon-count record stream that the pulse counter writes into the count FIFO on each RDY strobe.
- Pops one record at a time from the FIFO and holds it in a 64-bit register. The HPS reads the record as two 32-bit words over an Avalon-MM slave.
- Also provides status, flush, a sticky overflow flag and a consumed-record counter.

---
 rtl/cnt_stream_reader.sv | 184 ++++++++++++++++++
 tb/tb_cnt_stream_reader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_stream_reader.sv
// Count-FIFO record reader: pops 64-bit records into a hold register for Avalon-MM reads; CNT_RD_IRQ_EN adds a fill-level irq.
// Read latency 1, no waitrequest; a record must be consumed via DATA_HI before the next FIFO pop (3-cycle refetch).
module cnt_stream_reader #(
    parameter int FIFO_AW = 8
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [63:0]        fifo_q,
    input  logic               fifo_empty,
    input  logic               fifo_full,
    input  logic [FIFO_AW-1:0] fifo_usedw,
    output logic               fifo_rdreq,
    input  logic               wr_strobe,
    input  logic [1:0]         avs_address,
    input  logic               avs_read,
    input  logic               avs_write,
    input  logic [31:0]        avs_writedata,
`ifdef CNT_RD_IRQ_EN
    output logic               irq,
`endif
    output logic [31:0]        avs_readdata
);

    typedef enum logic [2:0] {
        S_EMPTY,
        S_FETCH,
        S_LOAD,
        S_FULL,
        S_FLUSH
    } state_t;

    state_t      state_q, state_d;
    logic        rdreq_q, rdreq_d;
    logic [63:0] hold_q, hold_d;
    logic        valid_q, valid_d;
    logic        enable_q, enable_d;
    logic        ovf_q, ovf_d;
    logic [31:0] rec_cnt_q, rec_cnt_d;
    logic [31:0] rdata_q, rdata_d;

    logic        ctrl_wr;
    logic        flush;
    logic        rd_hi;
    logic        inc;
    logic        usedw_one;
    logic [15:0] usedw_ext;
    logic        irq_bit;

    assign usedw_ext = 16'(fifo_usedw);
    assign usedw_one = (fifo_usedw == FIFO_AW'(1));
    assign ctrl_wr   = avs_write && (avs_address == 2'd3);
    assign flush     = ctrl_wr && avs_writedata[1];
    assign rd_hi     = avs_read && (avs_address == 2'd2);

`ifdef CNT_RD_IRQ_EN
    logic        irq_en_q, irq_en_d;
    logic [15:0] thresh_q, thresh_d;
    logic        irq_q, irq_d;
    logic        unused_wdata;

    assign unused_wdata = ^avs_writedata[15:5];
    assign irq_bit      = irq_q;
    assign irq          = irq_q;

    always_comb begin
        irq_en_d = irq_en_q;
        thresh_d = thresh_q;
        if (ctrl_wr) begin
            irq_en_d = avs_writedata[4];
            thresh_d = avs_writedata[31:16];
        end
        irq_d = irq_en_q && (thresh_q != 16'd0) && (usedw_ext >= thresh_q);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            irq_en_q <= 1'b0;
            thresh_q <= 16'd0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            thresh_q <= thresh_d;
            irq_q    <= irq_d;
        end
    end
`else
    logic unused_wdata;

    assign unused_wdata = ^avs_writedata[31:4];
    assign irq_bit      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rdreq_d = 1'b0;
        hold_d  = hold_q;
        valid_d = valid_q;
        inc     = 1'b0;

        case (state_q)
            S_EMPTY: begin
                if (enable_q && !fifo_empty) begin
                    state_d = S_FETCH;
                    rdreq_d = 1'b1;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                hold_d  = fifo_q;
                valid_d = 1'b1;
                state_d = S_FULL;
            end
            S_FULL: begin
                if (rd_hi) begin
                    valid_d = 1'b0;
                    inc     = 1'b1;
                    state_d = S_EMPTY;
                end
            end
            S_FLUSH: begin
                if (fifo_empty) begin
                    valid_d = 1'b0;
                    state_d = S_EMPTY;
                end else begin
                    // usedw lags our own pop by a cycle; skip the read that would underflow
                    rdreq_d = !(rdreq_q && usedw_one);
                end
            end
            default: state_d = S_EMPTY;
        endcase

        if (flush) begin
            state_d = S_FLUSH;
            inc     = 1'b0;
            rdreq_d = !fifo_empty && !(rdreq_q && usedw_one);
        end
    end

    always_comb begin
        enable_d  = ctrl_wr ? avs_writedata[0] : enable_q;
        ovf_d     = (wr_strobe && fifo_full) || (ovf_q && !(ctrl_wr && avs_writedata[2]));
        rec_cnt_d = rec_cnt_q;
        if (ctrl_wr && avs_writedata[3])
            rec_cnt_d = 32'd0;
        else if (inc)
            rec_cnt_d = rec_cnt_q + 32'd1;

        rdata_d = 32'd0;
        if (avs_read) begin
            case (avs_address)
                2'd0: rdata_d = {usedw_ext, 11'd0, irq_bit, enable_q, fifo_empty, ovf_q, valid_q};
                2'd1: rdata_d = valid_q ? hold_q[31:0]  : 32'd0;
                2'd2: rdata_d = valid_q ? hold_q[63:32] : 32'd0;
                default: rdata_d = rec_cnt_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_EMPTY;
            rdreq_q   <= 1'b0;
            hold_q    <= 64'd0;
            valid_q   <= 1'b0;
            enable_q  <= 1'b0;
            ovf_q     <= 1'b0;
            rec_cnt_q <= 32'd0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            rdreq_q   <= rdreq_d;
            hold_q    <= hold_d;
            valid_q   <= valid_d;
            enable_q  <= enable_d;
            ovf_q     <= ovf_d;
            rec_cnt_q <= rec_cnt_d;
            rdata_q   <= rdata_d;
        end
    end

    assign fifo_rdreq   = rdreq_q;
    assign avs_readdata = rdata_q;

endmodule

// File: tb/tb_cnt_stream_reader.sv
// Bench for cnt_stream_reader: queue FIFO model, read scoreboard with a decoupled monitor, randomized records.
module tb_cnt_stream_reader;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [63:0] fifo_q;
    logic        fifo_empty;
    logic        fifo_full;
    logic [7:0]  fifo_usedw;
    logic        fifo_rdreq;
    logic        wr_strobe;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
`ifdef CNT_RD_IRQ_EN
    logic        irq;
`endif

    always #5 CLK = ~CLK;

    cnt_stream_reader #(.FIFO_AW(8)) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .fifo_q        (fifo_q),
        .fifo_empty    (fifo_empty),
        .fifo_full     (fifo_full),
        .fifo_usedw    (fifo_usedw),
        .fifo_rdreq    (fifo_rdreq),
        .wr_strobe     (wr_strobe),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
`ifdef CNT_RD_IRQ_EN
        .irq           (irq),
`endif
        .avs_readdata  (avs_readdata)
    );

    int tests = 0;
    int fails = 0;

    logic [63:0] fq[$];
    logic [63:0] mq[$];
    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          m_cnt = 0;
    int          rdreq_cnt = 0;
    int          underflow = 0;
    logic        rdreq_seen = 1'b0;
    logic        rd_pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic upd();
        fifo_empty = (fq.size() == 0);
        fifo_usedw = 8'(fq.size());
    endtask

    task automatic push(input logic [63:0] r);
        fq.push_back(r);
        mq.push_back(r);
        upd();
    endtask

    // Normal-mode FIFO: a read requested in one cycle shows its word on fifo_q the next
    always @(negedge CLK) begin
        rdreq_seen = fifo_rdreq;
        if (fifo_rdreq) rdreq_cnt++;
    end

    always @(posedge CLK) begin
        if (rdreq_seen) begin
            #1;
            if (fq.size() > 0) fifo_q = fq.pop_front();
            else underflow++;
            upd();
        end
    end

    always @(posedge CLK) rd_pend <= avs_read;

    always @(negedge CLK) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_read", avs_readdata, 32'hDEAD_BEEF);
            end else begin
                logic [31:0] e;
                string       t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                chk(t, avs_readdata, e);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string name);
        avs_address = a;
        avs_read    = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(name);
        @(negedge CLK);
        avs_read = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_write     = 1'b1;
        avs_writedata = d;
        @(negedge CLK);
        avs_write = 1'b0;
    endtask

    function automatic logic [31:0] st(input bit v, input bit ov, input bit en, input bit irqb);
        return {16'(fq.size()), 11'd0, irqb, en, (fq.size() == 0), ov, v};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] r, r1, r2;
        int          n0;

        RESET_N       = 1'b0;
        fifo_q        = 64'd0;
        fifo_full     = 1'b0;
        wr_strobe     = 1'b0;
        avs_address   = 2'd0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = 32'd0;
        upd();

        tick(2);
        chk("rst_rdreq", 32'(fifo_rdreq), 32'd0);
        chk("rst_rdata", avs_readdata, 32'd0);
        RESET_N = 1'b1;
        tick(1);
        rd(2'd0, st(0, 0, 0, 0), "status_reset");

        // Enabled with an empty FIFO: nothing may be fetched
        wr(2'd3, 32'h1);
        tick(5);
        chk("no_rdreq_when_empty", rdreq_cnt, 0);
        rd(2'd0, st(0, 0, 1, 0), "status_enabled_empty");
        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd0, st(0, 0, 1, 0), "status_after_ignored_write");

        // Single known record and its fetch latency
        n0 = rdreq_cnt;
        push(64'h8000_0005_0000_03E8);
        tick(2);
        rd(2'd0, st(0, 0, 1, 0), "status_loading");
        rd(2'd0, st(1, 0, 1, 0), "status_valid");
        rd(2'd1, 32'h0000_03E8, "first_lo");
        rd(2'd2, 32'h8000_0005, "first_hi");
        void'(mq.pop_front());
        m_cnt++;
        rd(2'd3, 32'(m_cnt), "first_cnt");
        rd(2'd0, st(0, 0, 1, 0), "status_consumed");
        chk("single_rdreq_pulse", rdreq_cnt - n0, 1);

        wr(2'd3, 32'h9);
        m_cnt = 0;
        rd(2'd3, 32'd0, "cnt_cleared");

        // Three records read back-to-back at the minimum spacing
        for (int i = 0; i < 3; i++) push(rnd64());
        tick(3);
        for (int i = 0; i < 3; i++) begin
            r = mq.pop_front();
            rd(2'd2, r[63:32], "b2b_hi");
            m_cnt++;
            tick(2);
            rd(2'd0, st(0, 0, 1, 0), "b2b_gap_status");
        end
        rd(2'd3, 32'(m_cnt), "b2b_cnt");

        // Random records with random read delay
        for (int k = 0; k < 8; k++) begin
            r = (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : (k == 1) ? 64'd0 : rnd64();
            push(r);
            tick(3 + int'($urandom_range(0, 3)));
            r = mq.pop_front();
            rd(2'd1, r[31:0], "rand_lo");
            rd(2'd2, r[63:32], "rand_hi");
            m_cnt++;
            rd(2'd3, 32'(m_cnt), "rand_cnt");
        end

        // Disable while a record is held: it stays readable, nothing further is fetched
        r1 = rnd64();
        r2 = rnd64();
        push(r1);
        tick(3);
        n0 = rdreq_cnt;
        wr(2'd3, 32'h0);
        push(r2);
        void'(mq.pop_front());
        rd(2'd2, r1[63:32], "disabled_held_hi");
        m_cnt++;
        tick(6);
        chk("no_fetch_when_disabled", rdreq_cnt - n0, 0);
        rd(2'd0, st(0, 0, 0, 0), "status_disabled_pending");
        rd(2'd1, 32'd0, "lo_when_invalid");
        rd(2'd2, 32'd0, "hi_when_invalid");
        rd(2'd3, 32'(m_cnt), "cnt_after_invalid_reads");
        wr(2'd3, 32'h1);
        tick(3);
        void'(mq.pop_front());
        rd(2'd1, r2[31:0], "reenabled_lo");
        rd(2'd2, r2[63:32], "reenabled_hi");
        m_cnt++;

        // Sticky overflow; set beats a simultaneous clear
        fifo_full = 1'b1;
        wr_strobe = 1'b1;
        tick(1);
        wr_strobe = 1'b0;
        fifo_full = 1'b0;
        rd(2'd0, st(0, 1, 1, 0), "ovf_set");
        fifo_full = 1'b1;
        wr_strobe = 1'b1;
        wr(2'd3, 32'h5);
        wr_strobe = 1'b0;
        fifo_full = 1'b0;
        rd(2'd0, st(0, 1, 1, 0), "ovf_set_wins");
        wr(2'd3, 32'h5);
        rd(2'd0, st(0, 0, 1, 0), "ovf_cleared");

        // Flush with one record held and five queued
        for (int i = 0; i < 6; i++) push(rnd64());
        tick(4);
        n0 = rdreq_cnt;
        wr(2'd3, 32'h3);
        tick(10);
        mq.delete();
        chk("flush_rdreq_cycles", rdreq_cnt - n0, 5);
        rd(2'd0, st(0, 0, 1, 0), "flush_status");
        rd(2'd2, 32'd0, "flush_hi_invalid");
        rd(2'd3, 32'(m_cnt), "flush_cnt_unchanged");

`ifdef CNT_RD_IRQ_EN
        wr(2'd3, 32'h0004_0011);
        for (int i = 0; i < 4; i++) push(rnd64());
        tick(4);
        chk("irq_below_thresh", 32'(irq), 32'd0);
        push(rnd64());
        chk("irq_same_cycle", 32'(irq), 32'd0);
        tick(1);
        chk("irq_rise", 32'(irq), 32'd1);
        rd(2'd0, st(1, 0, 1, 1), "status_irq");
        r = mq.pop_front();
        rd(2'd2, r[63:32], "irq_consume_hi");
        m_cnt++;
        tick(2);
        chk("irq_hold", 32'(irq), 32'd1);
        tick(1);
        chk("irq_fall", 32'(irq), 32'd0);
        wr(2'd3, 32'h2);
        tick(12);
        mq.delete();
`endif

        // Asynchronous reset in the middle of a fetch
        wr(2'd3, 32'h1);
        push(rnd64());
        tick(1);
        chk("fetch_rdreq_high", 32'(fifo_rdreq), 32'd1);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("async_reset_rdreq", 32'(fifo_rdreq), 32'd0);
        tick(1);
        fq.delete();
        mq.delete();
        upd();
        RESET_N = 1'b1;
        tick(1);
        rd(2'd0, st(0, 0, 0, 0), "status_after_reset");
        rd(2'd3, 32'd0, "cnt_after_reset");

        tick(2);
        chk("no_underflow", underflow, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
